reg_alu_datapath: RTL and testbench

- Register-file + ALU datapath that executes the control words issued by the team's FSM control units (IE/WE/WA/REA/RAA/REB/RAB/S_ALU/Cin/OE).
- It is the responder side of that control interface: it returns the write-back bus (Datapath) for branch decisions and drives the registered result output.
- Single clock domain; one control word is consumed per cycle.

---
 rtl/reg_alu_datapath_pkg.sv | 25 ++
 rtl/reg_alu_datapath_if.sv | 30 +++
 rtl/reg_alu_datapath_alu_unit.sv | 47 ++++
 rtl/reg_alu_datapath.sv | 62 ++++++
 tb/tb_reg_alu_datapath.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/reg_alu_datapath_pkg.sv
// reg_alu_datapath_pkg: ALU opcodes, default sizes and flag bit positions for reg_alu_datapath
package reg_alu_datapath_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_ADDR  = 4;
    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_SUB   = 4'h1;
    localparam logic [3:0] ALU_AND   = 4'h2;
    localparam logic [3:0] ALU_OR    = 4'h3;
    localparam logic [3:0] ALU_XOR   = 4'h4;
    localparam logic [3:0] ALU_NOTA  = 4'h5;
    localparam logic [3:0] ALU_INC   = 4'h6;
    localparam logic [3:0] ALU_DEC   = 4'h7;
    localparam logic [3:0] ALU_SHL   = 4'h8;
    localparam logic [3:0] ALU_SHR   = 4'h9;
    localparam logic [3:0] ALU_MUL   = 4'hA;
    localparam logic [3:0] ALU_PASSA = 4'hB;
    localparam logic [3:0] ALU_PASSB = 4'hC;
    localparam logic [3:0] ALU_ASR   = 4'hD;
    localparam logic [3:0] ALU_ZERO  = 4'hE;
    localparam logic [3:0] ALU_ONE   = 4'hF;
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;
endpackage

// File: rtl/reg_alu_datapath_if.sv
// reg_alu_datapath_if: control word from the control unit and the datapath's status/result returns
interface reg_alu_datapath_if
    import reg_alu_datapath_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ADDR  = DEF_ADDR
);
    logic [WIDTH-1:0] Data_in;
    logic             IE;
    logic             WE;
    logic [ADDR-1:0]  WA;
    logic             REA;
    logic [ADDR-1:0]  RAA;
    logic             REB;
    logic [ADDR-1:0]  RAB;
    logic [3:0]       S_ALU;
    logic             Cin;
    logic             OE;
    logic [WIDTH-1:0] Datapath;
    logic [WIDTH-1:0] Out;
    logic             Out_valid;
    modport master (
        output Data_in, IE, WE, WA, REA, RAA, REB, RAB, S_ALU, Cin, OE,
        input  Datapath, Out, Out_valid
    );
    modport slave (
        input  Data_in, IE, WE, WA, REA, RAA, REB, RAB, S_ALU, Cin, OE,
        output Datapath, Out, Out_valid
    );
endinterface

// File: rtl/reg_alu_datapath_alu_unit.sv
// alu_unit: combinational ALU; overflow output exists only with DATAPATH_FLAGS_EN
module alu_unit
    import reg_alu_datapath_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             cin,
    output logic [WIDTH-1:0] y,
    output logic             c
`ifdef DATAPATH_FLAGS_EN
    ,
    output logic             v
`endif
);
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic             arith;
    // ADD, SUB, INC and DEC all share one adder; only the second operand differs
    always_comb begin
        addend = op == ALU_ADD ? b : op == ALU_SUB ? ~b : op == ALU_INC ? '0 : '1;
        sum    = {1'b0, a} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};
        arith  = op == ALU_ADD || op == ALU_SUB || op == ALU_INC || op == ALU_DEC;
        c      = arith ? sum[WIDTH] : 1'b0;
        case (op)
            ALU_AND:   y = a & b;
            ALU_OR:    y = a | b;
            ALU_XOR:   y = a ^ b;
            ALU_NOTA:  y = ~a;
            ALU_SHL:   y = a << 1;
            ALU_SHR:   y = a >> 1;
            ALU_MUL:   y = a * b;
            ALU_PASSA: y = a;
            ALU_PASSB: y = b;
            ALU_ASR:   y = $signed(a) >>> 1;
            ALU_ZERO:  y = '0;
            ALU_ONE:   y = {{(WIDTH-1){1'b0}}, 1'b1};
            default:   y = sum[WIDTH-1:0];
        endcase
    end
`ifdef DATAPATH_FLAGS_EN
    assign v = (op == ALU_ADD || op == ALU_SUB) && a[WIDTH-1] == addend[WIDTH-1]
               && sum[WIDTH-1] != a[WIDTH-1];
`endif
endmodule

// File: rtl/reg_alu_datapath.sv
// reg_alu_datapath: register file + ALU executing control words; DATAPATH_FLAGS_EN adds registered Flags {Z,C,N,V}
module reg_alu_datapath
    import reg_alu_datapath_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ADDR  = DEF_ADDR
) (
    input  logic CLK,
    input  logic RST,
    reg_alu_datapath_if.slave bus
`ifdef DATAPATH_FLAGS_EN
    ,
    output logic [3:0] Flags
`endif
);
    localparam int DEPTH = 2 ** ADDR;
    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] a, b, alu_y;
    logic             alu_c;
`ifdef DATAPATH_FLAGS_EN
    logic             alu_v;
`endif
    assign a = bus.REA ? regs[bus.RAA] : '0;
    assign b = bus.REB ? regs[bus.RAB] : '0;
    alu_unit #(.WIDTH(WIDTH)) u_alu (
        .a   (a),
        .b   (b),
        .op  (bus.S_ALU),
        .cin (bus.Cin),
        .y   (alu_y),
        .c   (alu_c)
`ifdef DATAPATH_FLAGS_EN
        ,
        .v   (alu_v)
`endif
    );
    assign bus.Datapath = bus.IE ? bus.Data_in : alu_y;
    // Out samples the pre-edge read port, so a same-cycle write to RAA is not seen
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            bus.Out       <= '0;
            bus.Out_valid <= 1'b0;
        end else begin
            if (bus.WE) regs[bus.WA] <= bus.Datapath;
            if (bus.OE) bus.Out <= a;
            bus.Out_valid <= bus.OE;
        end
    end
`ifdef DATAPATH_FLAGS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Flags <= '0;
        end else if (bus.WE && !bus.IE) begin
            Flags[FLAG_Z] <= alu_y == '0;
            Flags[FLAG_C] <= alu_c;
            Flags[FLAG_N] <= alu_y[WIDTH-1];
            Flags[FLAG_V] <= alu_v;
        end
    end
`endif
endmodule

// File: tb/tb_reg_alu_datapath.sv
// tb_reg_alu_datapath: directed plan plus random control words checked against an arithmetic model
module tb_reg_alu_datapath;
    import reg_alu_datapath_pkg::*;
    logic CLK = 0;
    logic RST = 1;
    int   tests = 0;
    int   fails = 0;
    logic chk_en = 0;
    reg_alu_datapath_if bus ();
`ifdef DATAPATH_FLAGS_EN
    logic [3:0] Flags;
    logic [3:0] m_flags;
`endif
    logic [15:0] m_regs [16];
    logic [15:0] m_out;
    logic        m_valid;
    reg_alu_datapath dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
`ifdef DATAPATH_FLAGS_EN
        ,
        .Flags (Flags)
`endif
    );
    always #5 CLK = ~CLK;
    // returns {V, C, Y} computed with wide integer arithmetic
    function automatic logic [17:0] ref_alu(input int unsigned a, input int unsigned b, input int op, input int cin);
        longint r;
        int     sa, sb, s;
        logic   c, v;
        int unsigned bb;
        case (op)
            0:  r = a + b + cin;
            1:  r = a + (b ^ 'hFFFF) + cin;
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  r = a ^ 'hFFFF;
            6:  r = a + cin;
            7:  r = a + 'hFFFF + cin;
            8:  r = a * 2;
            9:  r = a / 2;
            10: r = longint'(a) * longint'(b);
            11: r = a;
            12: r = b;
            13: r = (a / 2) + (a & 'h8000);
            14: r = 0;
            default: r = 1;
        endcase
        c  = (op <= 1 || op == 6 || op == 7) ? r[16] : 1'b0;
        bb = (op == 0) ? b : (b ^ 'hFFFF);
        sa = (a >= 32768) ? int'(a) - 65536 : int'(a);
        sb = (bb >= 32768) ? int'(bb) - 65536 : int'(bb);
        s  = sa + sb + cin;
        v  = op <= 1 && (s > 32767 || s < -32768);
        return {v, c, r[15:0]};
    endfunction
    function automatic int unsigned opa();
        return bus.REA ? m_regs[bus.RAA] : 0;
    endfunction
    function automatic int unsigned opb();
        return bus.REB ? m_regs[bus.RAB] : 0;
    endfunction
    function automatic logic [17:0] ref_word();
        return ref_alu(opa(), opb(), int'(bus.S_ALU), int'(bus.Cin));
    endfunction
    function automatic logic [15:0] ref_dp();
        logic [17:0] w;
        w = ref_word();
        return bus.IE ? bus.Data_in : w[15:0];
    endfunction
    function automatic logic [3:0] ref_flags();
        logic [17:0] w;
        w = ref_word();
        return {w[15:0] == 16'h0, w[16], w[15], w[17]};
    endfunction
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 16; i++) m_regs[i] <= '0;
            m_out   <= '0;
            m_valid <= 1'b0;
`ifdef DATAPATH_FLAGS_EN
            m_flags <= '0;
`endif
        end else begin
            if (bus.WE) m_regs[bus.WA] <= ref_dp();
            if (bus.OE) m_out <= 16'(opa());
            m_valid <= bus.OE;
`ifdef DATAPATH_FLAGS_EN
            if (bus.WE && !bus.IE) m_flags <= ref_flags();
`endif
        end
    end
    always @(negedge CLK) begin
        if (chk_en && !RST) begin
            chk("datapath", 32'(bus.Datapath), 32'(ref_dp()));
            chk("out", 32'(bus.Out), 32'(m_out));
            chk("out_valid", 32'(bus.Out_valid), 32'(m_valid));
`ifdef DATAPATH_FLAGS_EN
            chk("flags", 32'(Flags), 32'(m_flags));
`endif
        end
    end
    task automatic drive(input logic ie, input logic we, input logic [3:0] wa, input logic rea, input logic [3:0] raa,
                         input logic reb, input logic [3:0] rab, input logic [3:0] op, input logic cin, input logic oe,
                         input logic [15:0] din);
        bus.IE = ie; bus.WE = we; bus.WA = wa; bus.REA = rea; bus.RAA = raa; bus.REB = reb; bus.RAB = rab;
        bus.S_ALU = op; bus.Cin = cin; bus.OE = oe; bus.Data_in = din;
        #1;
    endtask
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask
    task automatic load(input logic [3:0] r, input logic [15:0] val);
        drive(1, 1, r, 0, 0, 0, 0, ALU_ZERO, 0, 0, val);
        tick();
    endtask
    initial begin
        logic [15:0] dp_now;
        bit done;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("ref_sub", 32'(ref_alu(5, 3, 1, 1)), 32'h10002);
        chk("ref_asr", 32'(ref_alu('h8002, 0, 13, 0)), 32'h0C001);
        chk("ref_ovf", 32'(ref_alu('h7FFF, 1, 0, 0)), 32'h28000);
        chk("ref_dec0", 32'(ref_alu(0, 0, 7, 0)), 32'h0FFFF);
        tick(); tick();
        RST = 0;
        chk_en = 1;
        // asynchronous reset mid-cycle
        load(5, 16'h1234);
        drive(0, 0, 0, 1, 5, 0, 0, ALU_PASSA, 0, 1, 0);
        chk("rst_pre_dp", 32'(bus.Datapath), 32'h1234);
        tick();
        chk("rst_pre_out", 32'(bus.Out), 32'h1234);
        chk("rst_pre_valid", 32'(bus.Out_valid), 1);
        RST = 1;
        #1;
        chk("rst_r5", 32'(bus.Datapath), 0);
        chk("rst_out", 32'(bus.Out), 0);
        chk("rst_valid", 32'(bus.Out_valid), 0);
        RST = 0;
        tick();
        // load and read back
        drive(1, 1, 1, 0, 0, 0, 0, ALU_ZERO, 0, 0, 16'h0005);
        chk("load_dp", 32'(bus.Datapath), 5);
        tick();
        drive(0, 0, 0, 1, 1, 0, 0, ALU_PASSA, 0, 1, 0);
        chk("load_r1", 32'(bus.Datapath), 5);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, ALU_ZERO, 0, 0, 0);
        chk("load_out", 32'(bus.Out), 5);
        chk("load_valid", 32'(bus.Out_valid), 1);
        tick();
        chk("load_valid_end", 32'(bus.Out_valid), 0);
        // factorial of 5
        load(1, 5);
        load(3, 1);
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            drive(0, 1, 3, 1, 1, 1, 3, ALU_MUL, 0, 0, 0);
            tick();
            drive(0, 1, 1, 1, 1, 0, 0, ALU_DEC, 0, 0, 0);
            dp_now = bus.Datapath;
            tick();
            done = dp_now == 16'h1;
        end
        chk("fact_done", 32'(done), 1);
        drive(0, 0, 0, 1, 3, 0, 0, ALU_PASSA, 0, 0, 0);
        chk("fact_r3", 32'(bus.Datapath), 32'h78);
        // wrap and carry
        load(2, 16'hFFFF);
        load(4, 16'h0001);
        drive(0, 1, 6, 1, 2, 1, 4, ALU_ADD, 0, 0, 0);
        chk("wrap_dp", 32'(bus.Datapath), 0);
        tick();
`ifdef DATAPATH_FLAGS_EN
        chk("wrap_flags", 32'(Flags), 32'hC);
`endif
        // multiply truncation and disabled read ports
        load(1, 16'd300);
        load(3, 16'd300);
        drive(0, 0, 0, 1, 1, 1, 3, ALU_MUL, 0, 0, 0);
        chk("mul_trunc", 32'(bus.Datapath), 32'h5F90);
        drive(0, 0, 0, 0, 1, 0, 3, ALU_ADD, 1, 0, 0);
        chk("disabled_ports", 32'(bus.Datapath), 1);
        tick();
        // read-during-write hazard
        load(2, 16'h00AA);
        drive(1, 1, 2, 1, 2, 0, 0, ALU_PASSA, 0, 1, 16'h0055);
        tick();
        drive(0, 0, 0, 1, 2, 0, 0, ALU_PASSA, 0, 0, 0);
        chk("hazard_out", 32'(bus.Out), 32'hAA);
        chk("hazard_valid", 32'(bus.Out_valid), 1);
        chk("hazard_r2", 32'(bus.Datapath), 32'h55);
        tick();
        // random control words
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7, 4'($urandom), 1'($urandom), 4'($urandom),
                  1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
            tick();
        end
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
